hazard_sweep_ctrl: RTL and testbench

Sequencer that exercises the 3-input hazard-prone function block (out = (~c&~a) | (b&c)) through every single-bit input transition.
- For each transition it drives the block's a/b/c, samples the block's output every clock over an observation window, counts output toggles and classifies the transition (clean, static hazard, dynamic hazard, functional error).
- It sits between a test/config master (start/abort, result stream) and the combinational function block under characterisation.

---
 rtl/hazard_sweep_ctrl_if.sv | 27 ++
 rtl/hazard_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_hazard_sweep_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_sweep_ctrl_if.sv
// Control/result bundle between the test master and the hazard sweep sequencer.
// The master issues start/abort and accepts results; the slave is the sequencer.
interface hazard_sweep_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             res_valid;
    logic             res_ready;
    logic [2:0]       res_vec;
    logic [1:0]       res_bit;
    logic [1:0]       res_class;
    logic [CNT_W-1:0] res_toggles;
    logic [4:0]       hazard_cnt;

    modport master (
        output start, abort, res_ready,
        input  busy, done, res_valid, res_vec, res_bit, res_class, res_toggles, hazard_cnt
    );

    modport slave (
        input  start, abort, res_ready,
        output busy, done, res_valid, res_vec, res_bit, res_class, res_toggles, hazard_cnt
    );
endinterface

// File: rtl/hazard_sweep_ctrl.sv
// Hazard sweep sequencer: walks every single-bit transition of a 3-input
// function block, counts output toggles over an observation window and
// classifies each transition as clean, static hazard, dynamic hazard or
// functional error. Results are streamed out with a valid/ready handshake.
module hazard_sweep_ctrl #(
    parameter int         SETTLE  = 4,
    parameter logic [7:0] FUNC_TT = 8'h8D,
    parameter int         CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_sweep_ctrl_if.slave bus,
    output logic               dut_a,
    output logic               dut_b,
    output logic               dut_c,
    input  logic               dut_out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BASE    = 3'd1,
        ST_OBSERVE = 3'd2,
        ST_REPORT  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [7:0]       LAST_CYC = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TOG_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TOG_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TOG_ONE  = CNT_W'(32'd1);
    localparam logic [4:0]       HAZ_MAX  = 5'd31;

    // One-hot mask of the input being flipped: k=0 -> c, 1 -> b, 2 -> a.
    function automatic logic [2:0] flip_mask(input logic [1:0] k);
        case (k)
            2'd0:    flip_mask = 3'b001;
            2'd1:    flip_mask = 3'b010;
            2'd2:    flip_mask = 3'b100;
            default: flip_mask = 3'b000;
        endcase
    endfunction

    // Transition class from the final sample, golden before/after values and toggle count.
    function automatic logic [1:0] classify(input logic             final_v,
                                            input logic             eb,
                                            input logic             ea,
                                            input logic [CNT_W-1:0] tog);
        if (final_v != ea) begin
            classify = 2'd3;
        end else if ((eb == ea) && (tog > TOG_ZERO)) begin
            classify = 2'd1;
        end else if ((eb != ea) && (tog > TOG_ONE)) begin
            classify = 2'd2;
        end else begin
            classify = 2'd0;
        end
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       cyc_r, cyc_s;
    logic [2:0]       v_r, v_s;
    logic [1:0]       k_r, k_s;
    logic             prev_r, prev_s;
    logic [CNT_W-1:0] tog_r, tog_s;
    logic [2:0]       drv_r, drv_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             valid_r, valid_s;
    logic [2:0]       vec_r, vec_s;
    logic [1:0]       bit_r, bit_s;
    logic [1:0]       class_r, class_s;
    logic [CNT_W-1:0] tog_out_r, tog_out_s;
    logic [4:0]       haz_r, haz_s;

    logic [2:0]       mask_s;
    logic [CNT_W-1:0] tog_inc_s;
    logic [1:0]       class_calc_s;
    logic             is_hazard_s;
    logic [2:0]       nv_s;
    logic [1:0]       nk_s;
    logic             last_pair_s;

    assign mask_s       = flip_mask(k_r);
    assign tog_inc_s    = ((dut_out != prev_r) && (tog_r != TOG_MAX)) ? (tog_r + TOG_ONE) : tog_r;
    assign class_calc_s = classify(dut_out, FUNC_TT[v_r], FUNC_TT[v_r ^ mask_s], tog_inc_s);
    assign is_hazard_s  = (class_calc_s == 2'd1) || (class_calc_s == 2'd2);
    assign nk_s         = (k_r == 2'd2) ? 2'd0 : (k_r + 2'd1);
    assign nv_s         = (k_r == 2'd2) ? (v_r + 3'd1) : v_r;
    assign last_pair_s  = (v_r == 3'd7) && (k_r == 2'd2);

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_s   = state_r;
        cyc_s     = cyc_r;
        v_s       = v_r;
        k_s       = k_r;
        prev_s    = prev_r;
        tog_s     = tog_r;
        drv_s     = drv_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        valid_s   = valid_r;
        vec_s     = vec_r;
        bit_s     = bit_r;
        class_s   = class_r;
        tog_out_s = tog_out_r;
        haz_s     = haz_r;

        if (bus.abort && (state_r != ST_IDLE)) begin
            // Abort wins over a simultaneous handshake; drives and hazard count hold.
            state_s = ST_IDLE;
            cyc_s   = 8'd0;
            tog_s   = TOG_ZERO;
            busy_s  = 1'b0;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_s = ST_BASE;
                        cyc_s   = 8'd0;
                        v_s     = 3'd0;
                        k_s     = 2'd0;
                        tog_s   = TOG_ZERO;
                        haz_s   = 5'd0;
                        busy_s  = 1'b1;
                        drv_s   = 3'd0;
                    end else begin
                        busy_s  = 1'b0;
                    end
                end
                ST_BASE: begin
                    if (cyc_r == LAST_CYC) begin
                        state_s = ST_OBSERVE;
                        cyc_s   = 8'd0;
                        prev_s  = dut_out;
                        drv_s   = v_r ^ mask_s;
                    end else begin
                        cyc_s   = cyc_r + 8'd1;
                    end
                end
                ST_OBSERVE: begin
                    prev_s = dut_out;
                    tog_s  = tog_inc_s;
                    if (cyc_r == LAST_CYC) begin
                        state_s   = ST_REPORT;
                        cyc_s     = 8'd0;
                        valid_s   = 1'b1;
                        vec_s     = v_r;
                        bit_s     = k_r;
                        class_s   = class_calc_s;
                        tog_out_s = tog_inc_s;
                        if (is_hazard_s && (haz_r != HAZ_MAX)) begin
                            haz_s = haz_r + 5'd1;
                        end else begin
                            haz_s = haz_r;
                        end
                    end else begin
                        cyc_s = cyc_r + 8'd1;
                    end
                end
                ST_REPORT: begin
                    if (bus.res_ready) begin
                        valid_s = 1'b0;
                        tog_s   = TOG_ZERO;
                        v_s     = nv_s;
                        k_s     = nk_s;
                        if (last_pair_s) begin
                            state_s = ST_DONE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_BASE;
                            cyc_s   = 8'd0;
                            drv_s   = nv_s;
                        end
                    end else begin
                        valid_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; everything clears on async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cyc_r     <= 8'd0;
            v_r       <= 3'd0;
            k_r       <= 2'd0;
            prev_r    <= 1'b0;
            tog_r     <= TOG_ZERO;
            drv_r     <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
            vec_r     <= 3'd0;
            bit_r     <= 2'd0;
            class_r   <= 2'd0;
            tog_out_r <= TOG_ZERO;
            haz_r     <= 5'd0;
        end else begin
            state_r   <= state_s;
            cyc_r     <= cyc_s;
            v_r       <= v_s;
            k_r       <= k_s;
            prev_r    <= prev_s;
            tog_r     <= tog_s;
            drv_r     <= drv_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            valid_r   <= valid_s;
            vec_r     <= vec_s;
            bit_r     <= bit_s;
            class_r   <= class_s;
            tog_out_r <= tog_out_s;
            haz_r     <= haz_s;
        end
    end

    assign dut_a           = drv_r[2];
    assign dut_b           = drv_r[1];
    assign dut_c           = drv_r[0];
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.res_valid   = valid_r;
    assign bus.res_vec     = vec_r;
    assign bus.res_bit     = bit_r;
    assign bus.res_class   = class_r;
    assign bus.res_toggles = tog_out_r;
    assign bus.hazard_cnt  = haz_r;

endmodule

// File: tb/tb_hazard_sweep_ctrl.sv
// Bench for hazard_sweep_ctrl: a behavioural function block with programmable
// truth table and per-transition glitch masks, a sweep-level reference model,
// a table of fixed scenarios, abort/reset sequences and randomized sweeps.
module tb_hazard_sweep_ctrl;

    localparam int         SETTLE  = 4;
    localparam logic [7:0] FUNC_TT = 8'h8D;
    localparam int         CNT_W   = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic dut_a, dut_b, dut_c;
    logic dut_out;

    hazard_sweep_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_sweep_ctrl #(.SETTLE(SETTLE), .FUNC_TT(FUNC_TT), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dut_a   (dut_a),
        .dut_b   (dut_b),
        .dut_c   (dut_c),
        .dut_out (dut_out)
    );

    always #5 clk = ~clk;

    // Function block model: truth table tt_blk plus a 3-bit glitch mask chosen by
    // the {from,to} vector pair; mask bit j inverts the output on sample j+1 after a change.
    logic [7:0] tt_blk;
    logic [2:0] gmask [64];
    logic [2:0] drv;
    logic [2:0] last_vec = 3'd0;
    logic [2:0] cur_mask = 3'd0;
    logic [7:0] age      = 8'd100;
    logic       glitch;

    assign drv = {dut_a, dut_b, dut_c};

    // Track drive changes on the falling edge so sample j sees age j.
    always @(negedge clk) begin
        if (drv != last_vec) begin
            cur_mask <= gmask[{last_vec, drv}];
            age      <= 8'd1;
            last_vec <= drv;
        end else if (age < 8'd100) begin
            age <= age + 8'd1;
        end
    end

    always_comb begin
        glitch = 1'b0;
        case (age)
            8'd1:    glitch = cur_mask[0];
            8'd2:    glitch = cur_mask[1];
            8'd3:    glitch = cur_mask[2];
            default: glitch = 1'b0;
        endcase
    end

    assign dut_out = tt_blk[drv] ^ glitch;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({dut_a, dut_b, dut_c, bus.busy, bus.done, bus.res_valid, bus.res_vec,
                     bus.res_bit, bus.res_class, bus.res_toggles, bus.hazard_cnt});
    endfunction

    // Expected result stream for one sweep.
    logic [2:0] e_vec [24];
    logic [1:0] e_bit [24];
    logic [1:0] e_cls [24];
    int         e_tog [24];
    int         e_haz;
    int         sum_tog;
    int         n_c3;

    task automatic set_config(input logic [7:0] tt, input bit glitchy);
        tt_blk = tt;
        for (int i = 0; i < 64; i++) gmask[i] = 3'b000;
        if (glitchy) begin
            gmask[{3'b010, 3'b011}] = 3'b001;
            gmask[{3'b011, 3'b010}] = 3'b001;
        end
    endtask

    // Reference: replay the sample sequence each transition produces and apply the class rules.
    task automatic build_expected();
        int         haz;
        int         k;
        int         t;
        logic [2:0] v, w, m;
        logic       prev, s, eb, ea;
        logic [1:0] cls;
        haz = 0;
        for (int n = 0; n < 24; n++) begin
            v    = 3'(n / 3);
            k    = n % 3;
            w    = v ^ (3'b001 << k);
            m    = gmask[{v, w}];
            prev = tt_blk[v];
            t    = 0;
            s    = prev;
            for (int j = 1; j <= SETTLE; j++) begin
                s = tt_blk[w];
                if (j <= 3) s = s ^ m[j-1];
                if (s != prev) t = (t < 7) ? t + 1 : 7;
                prev = s;
            end
            eb = FUNC_TT[v];
            ea = FUNC_TT[w];
            if (s != ea)                     cls = 2'd3;
            else if ((eb == ea) && (t > 0))  cls = 2'd1;
            else if ((eb != ea) && (t > 1))  cls = 2'd2;
            else                             cls = 2'd0;
            if ((cls == 2'd1) || (cls == 2'd2)) haz = (haz < 31) ? haz + 1 : 31;
            e_vec[n] = v;
            e_bit[n] = 2'(k);
            e_cls[n] = cls;
            e_tog[n] = t;
        end
        e_haz = haz;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // mode 0: ready high; 1: random ready; 2: ready low 5 cycles on the third result.
    task automatic run_sweep(input int mode, input bit poke);
        int n          = 0;
        int cyc        = 1;
        int stall_left = 5;
        bit done_seen  = 1'b0;
        bit rdy;
        sum_tog = 0;
        n_c3    = 0;
        build_expected();
        bus.res_ready = 1'b1;
        pulse_start();
        check("busy_after_start", int'(bus.busy), 1);
        check("hazard_cleared", int'(bus.hazard_cnt), 0);
        while (!done_seen && cyc < 3000) begin
            if (bus.done) begin
                done_seen = 1'b1;
                bus.start = 1'b0;
            end else begin
                if (bus.res_valid) begin
                    if (n < 24)
                        check($sformatf("result_%0d", n),
                              int'({bus.res_vec, bus.res_bit, bus.res_class, bus.res_toggles}),
                              int'({e_vec[n], e_bit[n], e_cls[n], 3'(e_tog[n])}));
                    else
                        check("extra_result", n, 23);
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        if ((n == 2) && (stall_left > 0) && (bus.res_valid || (stall_left < 5))) begin
                            check("stall_valid", int'(bus.res_valid), 1);
                            rdy = 1'b0;
                            stall_left--;
                        end else begin
                            rdy = 1'b1;
                        end
                    end
                endcase
                bus.res_ready = rdy;
                if (bus.res_valid && rdy) begin
                    sum_tog += int'(bus.res_toggles);
                    if (bus.res_class == 2'd3) n_c3++;
                    n++;
                end
                bus.start = poke && bus.busy && ($urandom_range(0, 7) == 0);
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        check("done_seen", int'(done_seen), 1);
        check("result_count", n, 24);
        check("busy_in_done", int'(bus.busy), 0);
        check("hazard_model", int'(bus.hazard_cnt), e_haz);
        if (mode == 0) check("done_cycle", cyc, 1 + 24 * 9);
        @(posedge clk); #1;
        check("done_one_cycle", int'(bus.done), 0);
    endtask

    task automatic abort_in_observe();
        int n     = 0;
        int waitc = 0;
        bit seen  = 1'b0;
        set_config(FUNC_TT, 1'b1);
        build_expected();
        bus.res_ready = 1'b1;
        pulse_start();
        while ((n < 9) && (waitc < 1000)) begin
            if (bus.res_valid) begin
                check($sformatf("abort_result_%0d", n),
                      int'({bus.res_vec, bus.res_bit, bus.res_class, bus.res_toggles}),
                      int'({e_vec[n], e_bit[n], e_cls[n], 3'(e_tog[n])}));
                n++;
            end
            @(posedge clk); #1;
            waitc++;
        end
        check("abort_reached_result_10", n, 9);
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_valid", int'(bus.res_valid), 0);
        check("abort_hazard_hold", int'(bus.hazard_cnt), 1);
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy || bus.res_valid) seen = 1'b1;
        end
        check("abort_stays_idle", int'(seen), 0);
    endtask

    task automatic reset_mid_report();
        int waitc = 0;
        bit seen  = 1'b0;
        set_config(FUNC_TT, 1'b0);
        bus.res_ready = 1'b1;
        pulse_start();
        while (!bus.res_valid && (waitc < 100)) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("report_reached", int'(bus.res_valid), 1);
        #3 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 0);
        #3 rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1'b1;
        end
        check("reset_no_done", int'(seen), 0);
    endtask

    typedef struct {
        logic [7:0] tt;
        bit         glitchy;
        int         mode;
        bit         poke;
        int         haz;
        int         c3;
        int         tog;
    } sweep_vec_t;

    sweep_vec_t tbl [3];

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b1;
        set_config(FUNC_TT, 1'b0);

        // {block truth table, glitch, ready mode, start pokes, hazards, class-3 count, toggle sum}
        tbl[0] = '{8'h8D, 1'b0, 0, 1'b0, 0, 0,  12};
        tbl[1] = '{8'h8D, 1'b1, 0, 1'b1, 2, 0,  16};
        tbl[2] = '{8'h00, 1'b0, 2, 1'b0, 0, 12, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            set_config(tbl[i].tt, tbl[i].glitchy);
            run_sweep(tbl[i].mode, tbl[i].poke);
            check($sformatf("tbl%0d_hazard", i), int'(bus.hazard_cnt), tbl[i].haz);
            check($sformatf("tbl%0d_class3", i), n_c3, tbl[i].c3);
            check($sformatf("tbl%0d_toggles", i), sum_tog, tbl[i].tog);
        end

        abort_in_observe();
        set_config(FUNC_TT, 1'b0);
        run_sweep(0, 1'b0);
        check("restart_toggles", sum_tog, 12);

        reset_mid_report();

        for (int r = 0; r < 5; r++) begin
            tt_blk = 8'($urandom);
            for (int i = 0; i < 64; i++)
                gmask[i] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            run_sweep(1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
